// File: rtl/versatile_fifo_sync_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM (port A write, port B registered read).
// Optional level / almost-full / almost-empty logic is enabled by defining VERSATILE_FIFO_LEVEL_EN.
module versatile_fifo_sync_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

    // Thresholds beyond the RAM depth can never be reached; catch them at elaboration.
    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_cfg_check
        $error("versatile_fifo_sync_ctrl: AF_LEVEL/AE_LEVEL exceed FIFO depth");
    end

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic                  push;
    logic                  pop;

    // Flags decode from pointer registers only.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // rst_n gating keeps the RAM write strobe quiet while reset is held.
    assign push = wr_req && !full && rst_n;
    assign pop  = rd_req && !empty && rst_n;

    assign ram_we_a  = push;
    assign ram_adr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_d_a   = wr_data;
    assign ram_adr_b = rd_ptr[ADDR_WIDTH-1:0];

    // RAM already registers the address, so data is passed through in the valid cycle and held after.
    assign rd_data = rd_valid ? ram_q_b : rd_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_hold   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            if (rd_valid) begin
                rd_hold <= ram_q_b;
            end
            rd_valid  <= pop;
            overflow  <= wr_req && full;
            underflow <= rd_req && empty;
        end
    end

`ifdef VERSATILE_FIFO_LEVEL_EN
    // Modulo subtraction stays correct across pointer wrap.
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= PTR_WIDTH'(AF_LEVEL));
    assign almost_empty = (level <= PTR_WIDTH'(AE_LEVEL));
`else
    assign level        = '0;
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_versatile_fifo_sync_ctrl.sv
// Directed self-checking bench for versatile_fifo_sync_ctrl at depth 4 with a behavioural RAM.
// Works with VERSATILE_FIFO_LEVEL_EN defined or undefined.
module tb_versatile_fifo_sync_ctrl;

`ifdef VERSATILE_FIFO_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       full;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       overflow;
    logic       underflow;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;
    logic [7:0] ram_d_a;
    logic [1:0] ram_adr_a;
    logic       ram_we_a;
    logic [1:0] ram_adr_b;
    logic [7:0] ram_q_b;

    logic [7:0] mem [0:3];
    int         wr_count = 0;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // Dual-port RAM: synchronous write on A, registered-address read on B.
    always @(posedge clk) begin
        if (ram_we_a) begin
            mem[ram_adr_a] <= ram_d_a;
            wr_count       <= wr_count + 1;
        end
        ram_q_b <= mem[ram_adr_b];
    end

    versatile_fifo_sync_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2),
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .full        (full),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .ram_d_a     (ram_d_a),
        .ram_adr_a   (ram_adr_a),
        .ram_we_a    (ram_we_a),
        .ram_adr_b   (ram_adr_b),
        .ram_q_b     (ram_q_b)
    );

    // Apply request inputs, then settle 1ns so combinational outputs can be observed.
    task automatic drive(input logic wr, input logic [7:0] d, input logic rd);
        wr_req  = wr;
        wr_data = d;
        rd_req  = rd;
        #1;
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] lv(input int n);
        return LVL ? 3'(n) : 3'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'h77, 1'b1);
        tick();
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full); end
        checks++; if (ram_we_a !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", ram_we_a); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0h exp=0", level); end
        checks++; if (almost_empty !== LVL) begin failures++; $display("FAIL reset_ae got=%0h exp=%0h", almost_empty, LVL); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%0h exp=0", almost_full); end
        checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%0b exp=000", {rd_valid, overflow, underflow}); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA1 + 8'(i), 1'b0);
            checks++; if (ram_we_a !== 1'b1 || ram_adr_a !== 2'(i) || ram_d_a !== 8'hA1 + 8'(i)) begin
                failures++; $display("FAIL fill_write%0d got we=%0h adr=%0h d=%0h exp we=1 adr=%0h d=%0h", i, ram_we_a, ram_adr_a, ram_d_a, i, 8'hA1 + 8'(i));
            end
            tick();
        end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL fill_full got full=%0h empty=%0h exp full=1 empty=0", full, empty); end
        checks++; if (level !== lv(4)) begin failures++; $display("FAIL fill_level got=%0h exp=%0h", level, lv(4)); end
        checks++; if (almost_full !== LVL || almost_empty !== 1'b0) begin failures++; $display("FAIL fill_af got af=%0h ae=%0h exp af=%0h ae=0", almost_full, almost_empty, LVL); end
        drive(1'b1, 8'h55, 1'b0);
        checks++; if (ram_we_a !== 1'b0) begin failures++; $display("FAIL ovf_we got=%0h exp=0", ram_we_a); end
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%0h exp=1", overflow); end
        checks++; if (wr_count !== 4 || mem[0] !== 8'hA1) begin failures++; $display("FAIL ovf_ram got writes=%0d mem0=%0h exp writes=4 mem0=a1", wr_count, mem[0]); end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_single got=%0h exp=0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA1 + 8'(i)) begin
                failures++; $display("FAIL drain%0d got valid=%0h data=%0h exp valid=1 data=%0h", i, rd_valid, rd_data, 8'hA1 + 8'(i));
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'hA4) begin failures++; $display("FAIL drain_hold got valid=%0h data=%0h exp valid=0 data=a4", rd_valid, rd_data); end
        checks++; if (empty !== 1'b1 || level !== 3'd0 || almost_empty !== LVL) begin
            failures++; $display("FAIL drain_empty got empty=%0h level=%0h ae=%0h exp empty=1 level=0 ae=%0h", empty, level, almost_empty, LVL);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL udf_pulse got udf=%0h valid=%0h exp udf=1 valid=0", underflow, rd_valid); end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (underflow !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL udf_single got udf=%0h valid=%0h exp udf=0 valid=0", underflow, rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 1'b0);
            q.push_back(8'hB0 + 8'(i));
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b1);
            q.push_back(8'hC0 + 8'(i));
            tick();
            exp = q.pop_front();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp || level !== lv(2)) begin
                failures++; $display("FAIL b2b%0d got valid=%0h data=%0h level=%0h exp valid=1 data=%0h level=%0h", i, rd_valid, rd_data, level, exp, lv(2));
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            exp = q.pop_front();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin failures++; $display("FAIL b2b_drain%0d got valid=%0h data=%0h exp valid=1 data=%0h", i, rd_valid, rd_data, exp); end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b1);
        checks++; if (ram_we_a !== 1'b0) begin failures++; $display("FAIL fsim_we got=%0h exp=0", ram_we_a); end
        tick();
        checks++; if (overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'hD0) begin
            failures++; $display("FAIL fsim_ops got ovf=%0h valid=%0h data=%0h exp ovf=1 valid=1 data=d0", overflow, rd_valid, rd_data);
        end
        checks++; if (full !== 1'b0 || level !== lv(3)) begin failures++; $display("FAIL fsim_level got full=%0h level=%0h exp full=0 level=%0h", full, level, lv(3)); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || level !== 3'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin
            failures++; $display("FAIL rmid_async got empty=%0h level=%0h valid=%0h full=%0h exp 1 0 0 0", empty, level, rd_valid, full);
        end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL rmid_novalid got valid=%0h data=%0h exp valid=0 data=0", rd_valid, rd_data); end
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 8'h5A, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin failures++; $display("FAIL rmid_new got valid=%0h data=%0h exp valid=1 data=5a", rd_valid, rd_data); end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL rmid_end got empty=%0h valid=%0h exp empty=1 valid=0", empty, rd_valid); end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        rd_req  = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
